// File: rtl/board_engine.sv
// Per-player Battleship board: ship map, attack validation, hit/shot counters, SETUP/PLAY/DEAD FSM.
// All outputs registered (one-cycle latency) except alive; no backpressure, each strobe is evaluated on its edge.
module board_engine #(
  parameter int CELLS      = 16,
  parameter int SHIP_CELLS = 0,
  parameter int CW         = $clog2(CELLS + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [CELLS-1:0] place_vec,
  input  logic             place_ld,
  input  logic             start,
  input  logic [CELLS-1:0] opp_atk,
  input  logic             opp_atk_vld,
  input  logic [CELLS-1:0] own_atk,
  input  logic             own_atk_ld,
  output logic [CELLS-1:0] ships_left,
  output logic [CELLS-1:0] own_atk_q,
  output logic             atk_ok,
  output logic             atk_err,
  output logic             hit,
  output logic             miss,
  output logic             setup_err,
  output logic             alive,
  output logic [CW-1:0]    hit_cnt,
  output logic [CW-1:0]    shot_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_SETUP = 2'b00,
    ST_PLAY  = 2'b01,
    ST_DEAD  = 2'b10
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = CW'(CELLS);

  state_t           state_q, state_d;
  logic [CELLS-1:0] ships_q, ships_d;
  logic [CELLS-1:0] own_q, own_d;
  logic [CELLS-1:0] prev_q, prev_d;
  logic [CW-1:0]    hit_cnt_q, hit_cnt_d;
  logic [CW-1:0]    shot_cnt_q, shot_cnt_d;
  logic             ok_q, ok_d, err_q, err_d, hit_q, hit_d;
  logic             miss_q, miss_d, serr_q, serr_d;

  logic [CELLS-1:0] fresh_bits, lost_bits, ships_after;
  logic             atk_valid, start_ok;

  assign fresh_bits  = opp_atk & ~prev_q;
  assign lost_bits   = prev_q & ~opp_atk;
  assign atk_valid   = (lost_bits == '0) && $onehot(fresh_bits);
  assign ships_after = ships_q & ~fresh_bits;
  // An exact ship count is only enforced when SHIP_CELLS is non-zero.
  assign start_ok    = (|ships_q) &&
                       ((SHIP_CELLS == 0) || ($countones(ships_q) == SHIP_CELLS));

  always_comb begin
    state_d    = state_q;
    ships_d    = ships_q;
    own_d      = own_q;
    prev_d     = prev_q;
    hit_cnt_d  = hit_cnt_q;
    shot_cnt_d = shot_cnt_q;
    ok_d       = 1'b0;
    err_d      = 1'b0;
    hit_d      = 1'b0;
    miss_d     = 1'b0;
    serr_d     = 1'b0;
    case (state_q)
      ST_SETUP: begin
        if (place_ld) begin
          ships_d = place_vec;
        end else if (start) begin
          if (start_ok) state_d = ST_PLAY;
          else          serr_d  = 1'b1;
        end
      end
      ST_PLAY: begin
        if (own_atk_ld) own_d = own_atk;
        if (opp_atk_vld) begin
          if (atk_valid) begin
            prev_d     = opp_atk;
            ok_d       = 1'b1;
            shot_cnt_d = (shot_cnt_q == CNT_MAX) ? shot_cnt_q : shot_cnt_q + 1'b1;
            if (|(fresh_bits & ships_q)) begin
              ships_d   = ships_after;
              hit_d     = 1'b1;
              hit_cnt_d = (hit_cnt_q == CNT_MAX) ? hit_cnt_q : hit_cnt_q + 1'b1;
              if (ships_after == '0) state_d = ST_DEAD;
            end else begin
              miss_d = 1'b1;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_DEAD: begin
        state_d = ST_DEAD;
      end
      default: begin
        state_d = ST_SETUP;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= ST_SETUP;
      ships_q    <= '0;
      own_q      <= '0;
      prev_q     <= '0;
      hit_cnt_q  <= '0;
      shot_cnt_q <= '0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      serr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ships_q    <= ships_d;
      own_q      <= own_d;
      prev_q     <= prev_d;
      hit_cnt_q  <= hit_cnt_d;
      shot_cnt_q <= shot_cnt_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      serr_q     <= serr_d;
    end
  end

  assign ships_left = ships_q;
  assign own_atk_q  = own_q;
  assign atk_ok     = ok_q;
  assign atk_err    = err_q;
  assign hit        = hit_q;
  assign miss       = miss_q;
  assign setup_err  = serr_q;
  assign alive      = |ships_q;
  assign hit_cnt    = hit_cnt_q;
  assign shot_cnt   = shot_cnt_q;
  assign state      = state_q;

endmodule

// File: tb/tb_board_engine.sv
// Directed bench for board_engine: default 16-cell board, SHIP_CELLS=4 board and a 25-cell board.
module tb_board_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // shared stimulus for the 16-cell instances
  logic        clr, clr4, place_ld, start, opp_atk_vld, own_atk_ld;
  logic [15:0] place_vec, opp_atk, own_atk;

  logic [15:0] ships_left, own_atk_q;
  logic        atk_ok, atk_err, hit, miss, setup_err, alive;
  logic [4:0]  hit_cnt, shot_cnt;
  logic [1:0]  state;

  logic [15:0] u4_ships, u4_own;
  logic        u4_ok, u4_err, u4_hit, u4_miss, u4_serr, u4_alive;
  logic [4:0]  u4_hc, u4_sc;
  logic [1:0]  u4_state;

  logic        clr25, pl25, st25, vld25, ol25;
  logic [24:0] pv25, opp25, ov25;
  logic [24:0] w_ships, w_own;
  logic        w_ok, w_err, w_hit, w_miss, w_serr, w_alive;
  logic [4:0]  w_hc, w_sc;
  logic [1:0]  w_state;

  board_engine dut (
    .clk(clk), .clr(clr), .place_vec(place_vec), .place_ld(place_ld), .start(start),
    .opp_atk(opp_atk), .opp_atk_vld(opp_atk_vld), .own_atk(own_atk), .own_atk_ld(own_atk_ld),
    .ships_left(ships_left), .own_atk_q(own_atk_q), .atk_ok(atk_ok), .atk_err(atk_err),
    .hit(hit), .miss(miss), .setup_err(setup_err), .alive(alive),
    .hit_cnt(hit_cnt), .shot_cnt(shot_cnt), .state(state)
  );

  board_engine #(.CELLS(16), .SHIP_CELLS(4)) u4 (
    .clk(clk), .clr(clr4), .place_vec(place_vec), .place_ld(place_ld), .start(start),
    .opp_atk(opp_atk), .opp_atk_vld(opp_atk_vld), .own_atk(own_atk), .own_atk_ld(own_atk_ld),
    .ships_left(u4_ships), .own_atk_q(u4_own), .atk_ok(u4_ok), .atk_err(u4_err),
    .hit(u4_hit), .miss(u4_miss), .setup_err(u4_serr), .alive(u4_alive),
    .hit_cnt(u4_hc), .shot_cnt(u4_sc), .state(u4_state)
  );

  board_engine #(.CELLS(25)) u25 (
    .clk(clk), .clr(clr25), .place_vec(pv25), .place_ld(pl25), .start(st25),
    .opp_atk(opp25), .opp_atk_vld(vld25), .own_atk(ov25), .own_atk_ld(ol25),
    .ships_left(w_ships), .own_atk_q(w_own), .atk_ok(w_ok), .atk_err(w_err),
    .hit(w_hit), .miss(w_miss), .setup_err(w_serr), .alive(w_alive),
    .hit_cnt(w_hc), .shot_cnt(w_sc), .state(w_state)
  );

  typedef struct packed {
    logic [1:0]  st;
    logic [24:0] ships;
    logic [24:0] own;
    logic        ok, err, hit, miss, serr, alive;
    logic [4:0]  hc, sc;
  } obs_t;

  typedef struct {
    logic        pl;
    logic [15:0] pv;
    logic        st;
    logic        vld;
    logic [15:0] opp;
    logic        ol;
    logic [15:0] ov;
    obs_t        exp_o;
  } vec_t;

  int errors = 0;
  int checks = 0;
  vec_t vt[14];

  // p = {ok, err, hit, miss, setup_err, alive}
  function automatic obs_t e(input logic [1:0] s, input logic [24:0] sh, input logic [24:0] ow,
                             input logic [5:0] p, input logic [4:0] hc, input logic [4:0] sc);
    obs_t o;
    o.st = s; o.ships = sh; o.own = ow;
    {o.ok, o.err, o.hit, o.miss, o.serr, o.alive} = p;
    o.hc = hc; o.sc = sc;
    return o;
  endfunction

  function automatic vec_t mkv(input logic pl, input logic [15:0] pv, input logic st,
                               input logic vld, input logic [15:0] opp, input logic ol,
                               input logic [15:0] ov, input obs_t ex);
    vec_t v;
    v.pl = pl; v.pv = pv; v.st = st; v.vld = vld; v.opp = opp; v.ol = ol; v.ov = ov;
    v.exp_o = ex;
    return v;
  endfunction

  function automatic obs_t obs16();
    return '{st: state, ships: {9'd0, ships_left}, own: {9'd0, own_atk_q}, ok: atk_ok,
             err: atk_err, hit: hit, miss: miss, serr: setup_err, alive: alive,
             hc: hit_cnt, sc: shot_cnt};
  endfunction

  function automatic obs_t obs4();
    return '{st: u4_state, ships: {9'd0, u4_ships}, own: {9'd0, u4_own}, ok: u4_ok,
             err: u4_err, hit: u4_hit, miss: u4_miss, serr: u4_serr, alive: u4_alive,
             hc: u4_hc, sc: u4_sc};
  endfunction

  function automatic obs_t obs25();
    return '{st: w_state, ships: w_ships, own: w_own, ok: w_ok, err: w_err, hit: w_hit,
             miss: w_miss, serr: w_serr, alive: w_alive, hc: w_hc, sc: w_sc};
  endfunction

  task automatic chk(input string nm, input obs_t a, input obs_t x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got st=%0d ships=%h own=%h ok/err/hit/miss/serr/alive=%b%b%b%b%b%b hc=%0d sc=%0d, required st=%0d ships=%h own=%h ok/err/hit/miss/serr/alive=%b%b%b%b%b%b hc=%0d sc=%0d",
               nm, a.st, a.ships, a.own, a.ok, a.err, a.hit, a.miss, a.serr, a.alive, a.hc, a.sc,
               x.st, x.ships, x.own, x.ok, x.err, x.hit, x.miss, x.serr, x.alive, x.hc, x.sc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle16();
    place_ld = 1'b0; start = 1'b0; opp_atk_vld = 1'b0; own_atk_ld = 1'b0;
    place_vec = '0; opp_atk = '0; own_atk = '0;
  endtask

  initial begin
    vt[0]  = mkv(0, 16'h0000, 1, 1, 16'h0001, 1, 16'hFFFF, e(0, 25'h0, 25'h0, 6'b000010, 0, 0));
    vt[1]  = mkv(1, 16'h000F, 1, 0, 16'h0000, 0, 16'h0000, e(0, 25'hF, 25'h0, 6'b000001, 0, 0));
    vt[2]  = mkv(0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, e(1, 25'hF, 25'h0, 6'b000001, 0, 0));
    vt[3]  = mkv(0, 16'h0000, 0, 1, 16'h0001, 0, 16'h0000, e(1, 25'hE, 25'h0, 6'b101001, 1, 1));
    vt[4]  = mkv(0, 16'h0000, 0, 1, 16'h0101, 0, 16'h0000, e(1, 25'hE, 25'h0, 6'b100101, 1, 2));
    vt[5]  = mkv(0, 16'h0000, 0, 1, 16'h0101, 0, 16'h0000, e(1, 25'hE, 25'h0, 6'b010001, 1, 2));
    vt[6]  = mkv(0, 16'h0000, 0, 1, 16'h0701, 0, 16'h0000, e(1, 25'hE, 25'h0, 6'b010001, 1, 2));
    vt[7]  = mkv(0, 16'h0000, 0, 1, 16'h0100, 0, 16'h0000, e(1, 25'hE, 25'h0, 6'b010001, 1, 2));
    vt[8]  = mkv(0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, e(1, 25'hE, 25'h0, 6'b000001, 1, 2));
    vt[9]  = mkv(1, 16'hFFFF, 1, 0, 16'h0000, 1, 16'h5555, e(1, 25'hE, 25'h5555, 6'b000001, 1, 2));
    vt[10] = mkv(0, 16'h0000, 0, 1, 16'h0103, 0, 16'h0000, e(1, 25'hC, 25'h5555, 6'b101001, 2, 3));
    vt[11] = mkv(0, 16'h0000, 0, 1, 16'h0107, 0, 16'h0000, e(1, 25'h8, 25'h5555, 6'b101001, 3, 4));
    vt[12] = mkv(0, 16'h0000, 0, 1, 16'h010F, 1, 16'hABCD, e(2, 25'h0, 25'hABCD, 6'b101000, 4, 5));
    vt[13] = mkv(1, 16'h00FF, 1, 1, 16'h011F, 1, 16'h1234, e(2, 25'h0, 25'hABCD, 6'b000000, 4, 5));

    idle16();
    pl25 = 1'b0; st25 = 1'b0; vld25 = 1'b0; ol25 = 1'b0;
    pv25 = '0; opp25 = '0; ov25 = '0;
    clr = 1'b1; clr4 = 1'b1; clr25 = 1'b1;
    #12;
    chk("reset16", obs16(), e(0, 25'h0, 25'h0, 6'b000000, 0, 0));
    chk("reset4",  obs4(),  e(0, 25'h0, 25'h0, 6'b000000, 0, 0));
    chk("reset25", obs25(), e(0, 25'h0, 25'h0, 6'b000000, 0, 0));
    clr = 1'b0; clr4 = 1'b0; clr25 = 1'b0;

    for (int i = 0; i < 14; i++) begin
      place_ld = vt[i].pl; place_vec = vt[i].pv; start = vt[i].st;
      opp_atk_vld = vt[i].vld; opp_atk = vt[i].opp;
      own_atk_ld = vt[i].ol; own_atk = vt[i].ov;
      step();
      chk($sformatf("vec%0d", i), obs16(), vt[i].exp_o);
    end
    idle16();

    // async clear while a hit pulse and counters are live
    clr = 1'b1; #2; clr = 1'b0;
    place_ld = 1'b1; place_vec = 16'h000F; step();
    place_ld = 1'b0; start = 1'b1; step();
    start = 1'b0; opp_atk_vld = 1'b1; opp_atk = 16'h0001; step();
    chk("pre_clr", obs16(), e(1, 25'hE, 25'h0, 6'b101001, 1, 1));
    #2; clr = 1'b1; #1;
    chk("async_clr", obs16(), e(0, 25'h0, 25'h0, 6'b000000, 0, 0));
    opp_atk = 16'h0003; step();
    chk("clr_held", obs16(), e(0, 25'h0, 25'h0, 6'b000000, 0, 0));
    clr = 1'b0;
    idle16();

    // exact ship count required
    clr4 = 1'b1; #2; clr4 = 1'b0;
    place_ld = 1'b1; place_vec = 16'h0007; step();
    place_ld = 1'b0; start = 1'b1; step();
    chk("u4_3cells", obs4(), e(0, 25'h7, 25'h0, 6'b000011, 0, 0));
    start = 1'b0; place_ld = 1'b1; place_vec = 16'h000F; step();
    place_ld = 1'b0; start = 1'b1; step();
    chk("u4_4cells", obs4(), e(1, 25'hF, 25'h0, 6'b000001, 0, 0));
    idle16();

    // 25-cell board, top cell
    pl25 = 1'b1; pv25 = 25'h100000F; step();
    pl25 = 1'b0; st25 = 1'b1; step();
    chk("w_start", obs25(), e(1, 25'h100000F, 25'h0, 6'b000001, 0, 0));
    st25 = 1'b0; vld25 = 1'b1; opp25 = 25'h1000000; step();
    chk("w_hit24", obs25(), e(1, 25'h000000F, 25'h0, 6'b101001, 1, 1));
    step();
    chk("w_repeat", obs25(), e(1, 25'h000000F, 25'h0, 6'b010001, 1, 1));
    vld25 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
